pwm_carrier_sched: RTL and testbench
====================================

Name: pwm_carrier_sched

Overview:
- Controller for the 2-channel PWM comparator stage.
- Generates the shared up/down triangular carrier.
- Double-buffers the two compare values and transfers them to the comparator only at scheduled carrier events.
- Sequences the PWM enable so output starts and stops cleanly at a carrier valley. Its outputs carrier, compare_1, compare_2 and en_pwm drive the comparator stage directly.

Parameters:
PWMWIDTH, 16, width of carrier, period and compare values.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
ce  in  1  clock enable; carrier and FSM advance only when ce=1
period  in  PWMWIDTH  requested carrier peak value
cmp_1_in  in  PWMWIDTH  requested compare, channel 1
cmp_2_in  in  PWMWIDTH  requested compare, channel 2
cmp_wr  in  1  one-cycle strobe; capture cmp_1_in/cmp_2_in into the pending buffer
upd_mode  in  2  update schedule: 00 valley, 01 peak, 10 valley and peak, 11 immediate
run_req  in  1  level; 1 = run PWM, 0 = stop at next valley
carrier  out  PWMWIDTH  triangular carrier
compare_1  out  PWMWIDTH  active compare, channel 1
compare_2  out  PWMWIDTH  active compare, channel 2
en_pwm  out  1  PWM output enable
sync_valley  out  1  high while carrier=0 in RUN/STOP
sync_peak  out  1  high while carrier=active period in RUN/STOP
pending  out  1  pending buffer holds untransferred values
state  out  2  00 IDLE, 01 RUN, 10 STOP

Behaviour:
Reset (rst=1 at posedge, independent of ce):
- carrier=0, direction=up, active period=period input (0 forced to 1).
- compare_1=compare_2=0, pending regs=0, pending=0.
- en_pwm=0, state=IDLE, syncs=0.
- Reset mid-run aborts immediately: en_pwm drops the next edge, with no drain.

Registers and enables:
- All outputs are registered. sync_valley/sync_peak are decoded from registered state/carrier, so they are cycle-aligned with carrier.
- cmp_wr capture and upd_mode=11 transfers operate every cycle regardless of ce. All other logic holds when ce=0.

Carrier (RUN and STOP, ce=1):
- Counting up: increments; when carrier=active period, reverses and decrements next.
- Counting down: decrements; at 0 reverses and increments next.
- Full period is therefore 2*P cycles of ce.
- Peak event: carrier=P with dir up, ce=1. Valley event: carrier=0 with dir down, ce=1.
- Active period reloads from the period input only at a valley event, and at the IDLE->RUN transition. Period input 0 is treated as 1.
- No clamping of compare against period.

FSM:
- IDLE: carrier held 0, en_pwm=0. On run_req=1 & ce go to RUN. The same edge sets en_pwm=1, dir=up, carrier=0 (counting starts the following ce cycle), and transfers pending if pending=1.
- RUN: on run_req=0 go to STOP; en_pwm stays 1.
- STOP: keeps counting. At the next valley event go to IDLE with en_pwm=0 and carrier=0.
- STOP with run_req=1 again returns to RUN without dropping en_pwm.
- IDLE with no start condition: no events occur.

Shadow update:
- cmp_wr loads the pending regs and sets pending.
- At a transfer event selected by upd_mode, if pending=1: copy to compare_1/2 and clear pending.
- upd_mode=11: transfer on the edge after cmp_wr, in any state.
- cmp_wr coincident with a transfer event: the old pending values transfer; the new values land in the pending regs and pending stays 1.
- cmp_wr coincident with a transfer event while pending=0: nothing transfers; new values become pending.
- Back-to-back cmp_wr before an event: the last write wins.
- upd_mode change takes effect immediately.

Decomposition:
- Shared package pwm_pkg:
  - state encoding constants ST_IDLE/ST_RUN/ST_STOP
  - update-mode constants UPD_VALLEY/UPD_PEAK/UPD_BOTH/UPD_IMM
  - PWMWIDTH default
- One natural sub-module: pwm_tri_carrier (up/down counter, period reload at valley, peak/valley event outputs).
- Shadow logic and FSM stay in the top.

Test Plan:
1. Reset, then run_req=1, period=4, ce=1 -> en_pwm=1 after 1 edge; carrier sequence 0,1,2,3,4,3,2,1,0,1...; sync_peak high when carrier=4; sync_valley high when carrier=0.
2. Running, upd_mode=00, cmp_wr with 3/1 while carrier climbing -> pending=1; compare_1/2 unchanged until the valley event edge, then 3/1 and pending=0. With upd_mode=01, the change occurs at carrier=4 instead.
3. cmp_wr with 2/2 on the exact valley-event cycle, with pending holding 3/1 -> outputs become 3/1, pending regs 2/2, pending=1; 2/2 applies at the next valley.
4. run_req=0 while carrier=2 counting up -> state=STOP, en_pwm stays 1 through the peak; en_pwm=0 and state=IDLE on the valley-event edge; carrier then held 0.
5. period changed 4->6 mid-cycle -> carrier still peaks at 4; next half-cycle peaks at 6. period=0 -> carrier toggles 0,1,0,1.
6. ce toggling 1,0,1,0 -> carrier advances only on ce=1 cycles. upd_mode=11 cmp_wr during ce=0 -> compare_1 updates on the next edge. rst asserted in RUN -> all outputs zero on the next edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state encoding, update-mode codes and default width for pwm_carrier_sched
package pwm_pkg;
  localparam int PWM_WIDTH_DEF = 16;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_STOP = 2'b10} state_t;
  localparam logic [1:0] UPD_VALLEY = 2'b00;
  localparam logic [1:0] UPD_PEAK = 2'b01;
  localparam logic [1:0] UPD_BOTH = 2'b10;
  localparam logic [1:0] UPD_IMM = 2'b11;
endpackage

// File: rtl/pwm_carrier_sched_if.sv
// pwm_carrier_sched_if: control inputs (ce, period, cmp_*_in, cmp_wr, upd_mode, run_req) and comparator-stage outputs
interface pwm_carrier_sched_if #(parameter int PWMWIDTH = 16);
  logic ce;
  logic cmp_wr;
  logic run_req;
  logic [1:0] upd_mode;
  logic [PWMWIDTH-1:0] period;
  logic [PWMWIDTH-1:0] cmp_1_in;
  logic [PWMWIDTH-1:0] cmp_2_in;
  logic [PWMWIDTH-1:0] carrier;
  logic [PWMWIDTH-1:0] compare_1;
  logic [PWMWIDTH-1:0] compare_2;
  logic en_pwm;
  logic sync_valley;
  logic sync_peak;
  logic pending;
  logic [1:0] state;
  modport master (
    output ce, cmp_wr, run_req, upd_mode, period, cmp_1_in, cmp_2_in,
    input carrier, compare_1, compare_2, en_pwm, sync_valley, sync_peak, pending, state
  );
  modport slave (
    input ce, cmp_wr, run_req, upd_mode, period, cmp_1_in, cmp_2_in,
    output carrier, compare_1, compare_2, en_pwm, sync_valley, sync_peak, pending, state
  );
endinterface

// File: rtl/pwm_tri_carrier.sv
// pwm_tri_carrier: up/down triangle counter (clk, rst, ce, cnt, start, clr, period -> carrier, per, peak_ev, valley_ev)
module pwm_tri_carrier #(parameter int W = 16) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic cnt,
  input  logic start,
  input  logic clr,
  input  logic [W-1:0] period,
  output logic [W-1:0] carrier,
  output logic [W-1:0] per,
  output logic peak_ev,
  output logic valley_ev
);
  logic up;
  logic nup;
  logic [W-1:0] np;
  assign np = period == '0 ? W'(1) : period;
  assign peak_ev = cnt && ce && up && carrier == per;
  assign valley_ev = cnt && ce && !up && carrier == '0;
  assign nup = up ^ (peak_ev || valley_ev);
  always_ff @(posedge clk)
    if (rst || start) begin
      carrier <= '0;
      up <= 1'b1;
      per <= np;
    end else if (clr) begin
      carrier <= '0;
      up <= 1'b1;
    end else if (cnt && ce) begin
      carrier <= nup ? carrier + W'(1) : carrier - W'(1);
      up <= nup;
      if (valley_ev) per <= np;
    end
endmodule

// File: rtl/pwm_carrier_sched.sv
// pwm_carrier_sched: carrier, shadowed compares and valley-aligned enable sequencing (clk, rst, bus slave modport)
module pwm_carrier_sched import pwm_pkg::*; #(parameter int PWMWIDTH = PWM_WIDTH_DEF) (
  input logic clk,
  input logic rst,
  pwm_carrier_sched_if.slave bus
);
  state_t st, st_n;
  logic [PWMWIDTH-1:0] carrier, per, cmp_1, cmp_2, pend_1, pend_2;
  logic pend, en, start, clr, xfer, peak_ev, valley_ev;
  pwm_tri_carrier #(.W(PWMWIDTH)) u_car (
    .clk(clk),
    .rst(rst),
    .ce(bus.ce),
    .cnt(st != ST_IDLE),
    .start(start),
    .clr(clr),
    .period(bus.period),
    .carrier(carrier),
    .per(per),
    .peak_ev(peak_ev),
    .valley_ev(valley_ev)
  );
  always_comb begin
    st_n = st;
    if (bus.ce)
      st_n = st == ST_IDLE ? (bus.run_req ? ST_RUN : ST_IDLE)
           : bus.run_req ? ST_RUN
           : (st == ST_STOP && valley_ev) ? ST_IDLE : ST_STOP;
    start = bus.ce && st == ST_IDLE && bus.run_req;
    clr = st == ST_STOP && st_n == ST_IDLE;
    xfer = pend && (bus.upd_mode == UPD_IMM || start
         || (valley_ev && (bus.upd_mode == UPD_VALLEY || bus.upd_mode == UPD_BOTH))
         || (peak_ev && (bus.upd_mode == UPD_PEAK || bus.upd_mode == UPD_BOTH)));
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= ST_IDLE;
      en <= 1'b0;
      cmp_1 <= '0;
      cmp_2 <= '0;
      pend_1 <= '0;
      pend_2 <= '0;
      pend <= 1'b0;
    end else begin
      st <= st_n;
      en <= st_n != ST_IDLE;
      if (xfer) begin
        cmp_1 <= pend_1;
        cmp_2 <= pend_2;
      end
      if (bus.cmp_wr) begin
        pend_1 <= bus.cmp_1_in;
        pend_2 <= bus.cmp_2_in;
      end
      pend <= bus.cmp_wr || (pend && !xfer);
    end
  assign bus.carrier = carrier;
  assign bus.compare_1 = cmp_1;
  assign bus.compare_2 = cmp_2;
  assign bus.en_pwm = en;
  assign bus.pending = pend;
  assign bus.state = st;
  assign bus.sync_valley = st != ST_IDLE && carrier == '0;
  assign bus.sync_peak = st != ST_IDLE && carrier == per;
endmodule

// File: tb/tb_pwm_carrier_sched.sv
// tb_pwm_carrier_sched: random + directed self-check of pwm_carrier_sched against a phase-index reference model
module tb_pwm_carrier_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int seq [10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
  int ms, k, mp;
  logic [15:0] c1, c2, q1, q2;
  bit qv, armed;
  pwm_carrier_sched_if #(.PWMWIDTH(16)) bus ();
  pwm_carrier_sched #(.PWMWIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask
  function automatic int mcar();
    return k <= mp ? k : 2 * mp - k;
  endfunction
  always @(posedge clk) begin
    int np;
    bit ev_v, ev_p, start, xfer;
    np = bus.period == 0 ? 1 : int'(bus.period);
    if (rst) begin
      ms = 0; k = 0; mp = np; c1 = 0; c2 = 0; q1 = 0; q2 = 0; qv = 0; armed = 1;
    end else begin
      ev_v = bus.ce && ms != 0 && k == 2 * mp;
      ev_p = bus.ce && ms != 0 && k == mp;
      start = bus.ce && ms == 0 && bus.run_req;
      xfer = qv && (bus.upd_mode == 3 || start || (ev_v && (bus.upd_mode == 0 || bus.upd_mode == 2))
             || (ev_p && (bus.upd_mode == 1 || bus.upd_mode == 2)));
      if (xfer) begin c1 = q1; c2 = q2; qv = 0; end
      if (bus.cmp_wr) begin q1 = bus.cmp_1_in; q2 = bus.cmp_2_in; qv = 1; end
      if (start) begin
        ms = 1; k = 0; mp = np;
      end else if (bus.ce && ms != 0) begin
        if (ms == 2 && ev_v && !bus.run_req) begin
          ms = 0; k = 0;
        end else begin
          ms = bus.run_req ? 1 : 2;
          if (ev_v) begin k = 1; mp = np; end
          else k = k + 1;
        end
      end
    end
  end
  always @(negedge clk) if (armed) begin
    chk("carrier", bus.carrier, mcar());
    chk("compare_1", bus.compare_1, c1);
    chk("compare_2", bus.compare_2, c2);
    chk("en_pwm", bus.en_pwm, ms != 0);
    chk("state", bus.state, ms);
    chk("pending", bus.pending, qv);
    chk("sync_valley", bus.sync_valley, ms != 0 && mcar() == 0);
    chk("sync_peak", bus.sync_peak, ms != 0 && mcar() == mp);
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  initial begin
    bus.ce = 1'b0; bus.cmp_wr = 1'b0; bus.run_req = 1'b0; bus.upd_mode = 2'b00;
    bus.period = 16'd4; bus.cmp_1_in = '0; bus.cmp_2_in = '0;
    step();
    step();
    chk("rst_carrier", bus.carrier, 0);
    chk("rst_en", bus.en_pwm, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_cmp1", bus.compare_1, 0);
    rst = 1'b0; bus.ce = 1'b1; bus.run_req = 1'b1;
    step();
    chk("start_en", bus.en_pwm, 1);
    chk("start_state", bus.state, 1);
    chk("start_carrier", bus.carrier, seq[0]);
    for (int i = 1; i < 10; i++) begin
      step();
      chk("seq_carrier", bus.carrier, seq[i]);
      chk("seq_model", mcar(), seq[i]);
      chk("seq_peak", bus.sync_peak, seq[i] == 4);
    end
    bus.cmp_wr = 1'b1; bus.cmp_1_in = 16'd3; bus.cmp_2_in = 16'd1;
    step();
    bus.cmp_wr = 1'b0;
    chk("wr_pending", bus.pending, 1);
    chk("wr_cmp1_held", bus.compare_1, 0);
    for (int j = 1; j <= 7; j++) begin
      step();
      if (j == 6) chk("pre_valley_cmp1", bus.compare_1, 0);
      if (j == 7) begin
        chk("valley_cmp1", bus.compare_1, 3);
        chk("valley_cmp2", bus.compare_2, 1);
        chk("valley_pending", bus.pending, 0);
      end
    end
    bus.run_req = 1'b0;
    step();
    chk("stop_state", bus.state, 2);
    chk("stop_en", bus.en_pwm, 1);
    chk("stop_carrier", bus.carrier, 2);
    for (int j = 0; j < 6; j++) step();
    chk("stop_valley_en", bus.en_pwm, 1);
    chk("stop_valley_sync", bus.sync_valley, 1);
    step();
    chk("idle_state", bus.state, 0);
    chk("idle_en", bus.en_pwm, 0);
    chk("idle_carrier", bus.carrier, 0);
    bus.ce = 1'b0; bus.upd_mode = 2'b11; bus.cmp_wr = 1'b1; bus.cmp_1_in = 16'd9; bus.cmp_2_in = 16'd7;
    step();
    bus.cmp_wr = 1'b0;
    chk("imm_pending", bus.pending, 1);
    chk("imm_held", bus.compare_1, 3);
    step();
    chk("imm_cmp1", bus.compare_1, 9);
    chk("imm_cmp2", bus.compare_2, 7);
    chk("imm_pending_clr", bus.pending, 0);
    for (int n = 0; n < 4000; n++) begin
      rst = $urandom_range(0, 299) == 0;
      bus.ce = $urandom_range(0, 3) != 0;
      bus.cmp_wr = $urandom_range(0, 4) == 0;
      bus.cmp_1_in = 16'($urandom);
      bus.cmp_2_in = 16'($urandom);
      if ($urandom_range(0, 39) == 0) bus.run_req = ~bus.run_req;
      if ($urandom_range(0, 29) == 0) bus.upd_mode = 2'($urandom);
      if ($urandom_range(0, 19) == 0) bus.period = 16'($urandom_range(0, 7));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
